// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_engine
// Description : Word-by-word RAM copy / fill engine. Copy alternates a read
//               cycle and a write cycle per word; fill writes one word per
//               cycle. Pointers wrap modulo the RAM size.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [DATA_W-1:0] fill_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    rem_q;
    logic [LEN_W-1:0]    count_q;
    logic                mode_q;
    logic [DATA_W-1:0]   fill_q;
    logic [DATA_W-1:0]   data_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = S_DONE;
                    end else if (mode_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_WR;
            S_WR: begin
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch, read capture and per-word pointer/counter advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_q   <= src_i;
                        dst_q   <= dst_i;
                        rem_q   <= len_i;
                        mode_q  <= mode_i;
                        fill_q  <= fill_i;
                        count_q <= '0;
                    end
                end
                S_RD: begin
                    data_q <= mem_dout_i;
                end
                S_WR: begin
                    src_q   <= src_q + ADDR_W'(1);
                    dst_q   <= dst_q + ADDR_W'(1);
                    rem_q   <= rem_q - LEN_W'(1);
                    count_q <= count_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore output decode; the RAM bus is parked at zero outside RD/WR
    always_comb begin
        busy_o     = (state_q == S_RD) || (state_q == S_WR);
        done_o     = (state_q == S_DONE);
        count_o    = count_q;
        mem_addr_o = '0;
        mem_wen_o  = 1'b0;
        mem_din_o  = '0;
        if (state_q == S_RD) begin
            mem_addr_o = src_q;
        end else if (state_q == S_WR) begin
            mem_addr_o = dst_q;
            mem_wen_o  = 1'b1;
            mem_din_o  = mode_q ? fill_q : data_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_copy_engine
// Description : Scoreboard bench for ram_copy_engine with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_copy_engine;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [4:0] src_i = '0;
    logic [4:0] dst_i = '0;
    logic [5:0] len_i = '0;
    logic [7:0] fill_i = '0;
    logic       busy_o, done_o, mem_wen_o;
    logic [5:0] count_o;
    logic [4:0] mem_addr_o;
    logic [7:0] mem_din_o, mem_dout_i;

    logic [7:0] ram [32];
    logic [7:0] snap [32];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [12:0] exp_wr [$];   // {addr, data}
    logic [13:0] exp_done [$]; // {count, latency}

    ram_copy_engine #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .fill_i(fill_i),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_din_o(mem_din_o),
        .mem_dout_i(mem_dout_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Combinational read port; writes land mid-cycle, clear of the capture edge
    assign mem_dout_i = ram[mem_addr_o];
    always @(negedge clk_i) begin
        if (mem_wen_o) ram[mem_addr_o] = mem_din_o;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write and every done pulse
    always @(negedge clk_i) begin
        logic [12:0] w;
        logic [13:0] d;
        if (mem_wen_o) begin
            if (exp_wr.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, want no write", mem_addr_o, mem_din_o);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", int'(mem_addr_o), int'(w[12:8]));
                chk("wr_data", int'(mem_din_o), int'(w[7:0]));
            end
        end
        if (done_o) begin
            if (exp_done.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done pulse count=%0d, want none", count_o);
            end else begin
                d = exp_done.pop_front();
                chk("done_count", int'(count_o), int'(d[13:8]));
                chk("done_latency", cyc - start_cyc + 1, int'(d[7:0]));
            end
        end
    end

    task automatic push_wr(input int a, input int dv);
        exp_wr.push_back({5'(a), 8'(dv)});
    endtask

    task automatic push_done(input int c, input int lat);
        exp_done.push_back({6'(c), 8'(lat)});
    endtask

    task automatic start_cmd(input logic m, input int s, input int d, input int l, input int f);
        @(negedge clk_i);
        mode_i = m; src_i = 5'(s); dst_i = 5'(d); len_i = 6'(l); fill_i = 8'(f);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_cyc = cyc;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (exp_done.size() != 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done within 200 cycles, want done", nm);
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk({nm, "_writes_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'(i + 8'h40);
        ram[0] = 8'd3; ram[1] = 8'd2; ram[2] = 8'd4;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_wen", int'(mem_wen_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_addr", int'(mem_addr_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Copy 0..2 -> 8..10
        push_wr(8, 3); push_wr(9, 2); push_wr(10, 4);
        push_done(3, 7);
        start_cmd(1'b0, 0, 8, 3, 0);
        chk("copy_busy", int'(busy_o), 1);
        wait_done("copy");
        chk("ram8", int'(ram[8]), 3);
        chk("ram9", int'(ram[9]), 2);
        chk("ram10", int'(ram[10]), 4);
        chk("idle_count_hold", int'(count_o), 3);
        chk("idle_addr", int'(mem_addr_o), 0);

        // Fill with destination wrap
        for (int i = 0; i < 32; i++) snap[i] = ram[i];
        push_wr(28, 8'hAA); push_wr(29, 8'hAA); push_wr(30, 8'hAA);
        push_wr(31, 8'hAA); push_wr(0, 8'hAA); push_wr(1, 8'hAA);
        push_done(6, 7);
        start_cmd(1'b1, 0, 28, 6, 8'hAA);
        wait_done("fill");
        begin
            int diffs = 0;
            for (int i = 2; i < 28; i++) if (ram[i] !== snap[i]) diffs++;
            chk("fill_untouched_2_27", diffs, 0);
        end
        chk("ram31", int'(ram[31]), 8'hAA);
        chk("ram0_fill", int'(ram[0]), 8'hAA);

        // Copy with source wrap
        ram[30] = 8'h11; ram[31] = 8'h22; ram[0] = 8'd3; ram[1] = 8'd2;
        push_wr(4, 8'h11); push_wr(5, 8'h22); push_wr(6, 3); push_wr(7, 2);
        push_done(4, 9);
        start_cmd(1'b0, 30, 4, 4, 0);
        wait_done("wrapcopy");

        // Overlapping forward copy smears word 0
        ram[0] = 8'd3; ram[1] = 8'd2; ram[2] = 8'd4; ram[3] = 8'h99;
        push_wr(1, 3); push_wr(2, 3); push_wr(3, 3);
        push_done(3, 7);
        start_cmd(1'b0, 0, 1, 3, 0);
        wait_done("overlap");
        for (int i = 0; i < 4; i++) chk($sformatf("overlap_ram%0d", i), int'(ram[i]), 3);

        // Zero-length command
        push_done(0, 1);
        start_cmd(1'b0, 5, 6, 0, 0);
        wait_done("len0");
        chk("len0_count", int'(count_o), 0);

        // Second start while busy is ignored
        push_wr(16, 3); push_wr(17, 3);
        push_done(2, 5);
        start_cmd(1'b0, 0, 16, 2, 0);
        @(negedge clk_i);
        mode_i = 1'b1; dst_i = 5'd20; len_i = 6'd1; fill_i = 8'hEE; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done("ignore");
        chk("ignore_ram20", int'(ram[20]), 8'h54);

        // Reset during the second write of a 5-word fill
        push_wr(12, 8'h5C);
        start_cmd(1'b1, 0, 12, 5, 8'h5C);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("abort_wen", int'(mem_wen_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_count", int'(count_o), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("abort_writes_left", exp_wr.size(), 0);
        chk("abort_ram12", int'(ram[12]), 8'h5C);
        chk("abort_ram13", int'(ram[13]), 8'h4D);

        // Fresh command after the abort
        push_wr(20, 8'h77); push_wr(21, 8'h77);
        push_done(2, 3);
        start_cmd(1'b1, 0, 20, 2, 8'h77);
        wait_done("post_rst");
        chk("post_ram21", int'(ram[21]), 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
